// File: rtl/entity_motion_engine.sv
// entity_motion_engine
//   Owns the entity table (ship, asteroids, shots) and advances every live
//   slot once per move tick. Each slot gets its velocity applied, wraps at the
//   screen edges, and has its shot lifetime aged. A spawn handshake writes new
//   entities into the lowest free slot. A kill port lets collision logic clear
//   the alive bit of any slot.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   tick                  1-cycle move pulse from the rate divider
//   spawn_valid/_entity   spawn request and the entity to write
//   spawn_ready           combinational: engine can take a spawn this cycle
//   spawn_done/_slot      pulse + slot index of a completed spawn
//   spawn_full            pulse: spawn consumed, no free slot, dropped
//   kill_valid/_slot      clear the alive bit of kill_slot (out-of-range ignored)
//   entities              registered table, slot i = [i*ENTITY_SIZE +: ENTITY_SIZE]
//   busy                  sweep in progress
//   sweep_done            pulse after the last slot has been updated
//   tick_overrun          pulse: a tick was dropped
//
// Entity layout: [33] alive [32:26] life (0 = immortal) [25:16] y [15:6] x
//                [5:3] vy {sign,mag} [2:0] vx {sign,mag}, sign=1 is negative.

module entity_motion_engine #(
  parameter int unsigned NUM_ENTITIES = 7,
  parameter int unsigned ENTITY_SIZE  = 34,
  parameter int unsigned SCREEN_W     = 320,
  parameter int unsigned SCREEN_H     = 240,
  parameter int unsigned SLOT_W       = $clog2(NUM_ENTITIES)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 tick,
  input  logic                                 spawn_valid,
  input  logic [ENTITY_SIZE-1:0]               spawn_entity,
  output logic                                 spawn_ready,
  output logic                                 spawn_done,
  output logic [SLOT_W-1:0]                    spawn_slot,
  output logic                                 spawn_full,
  input  logic                                 kill_valid,
  input  logic [SLOT_W-1:0]                    kill_slot,
  output logic [NUM_ENTITIES*ENTITY_SIZE-1:0]  entities,
  output logic                                 busy,
  output logic                                 sweep_done,
  output logic                                 tick_overrun
);

  localparam int unsigned ALIVE_B = 33;
  localparam logic signed [10:0] XMOD = 11'(SCREEN_W);
  localparam logic signed [10:0] YMOD = 11'(SCREEN_H);
  localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(NUM_ENTITIES - 1);

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_e;

  state_e                   state_q, state_d;
  logic [SLOT_W-1:0]        cnt_q, cnt_d;
  logic                     pending_q, pending_d;
  logic [ENTITY_SIZE-1:0]   slots_q [NUM_ENTITIES];
  logic [ENTITY_SIZE-1:0]   slots_d [NUM_ENTITIES];
  logic                     spawn_done_q, spawn_done_d;
  logic                     spawn_full_q, spawn_full_d;
  logic [SLOT_W-1:0]        spawn_slot_q, spawn_slot_d;
  logic                     sweep_done_q, sweep_done_d;
  logic                     overrun_q, overrun_d;

  logic                     free_found;
  logic [SLOT_W-1:0]        free_idx;
  logic                     kill_ok;
  logic [ENTITY_SIZE-1:0]   spawn_wr;

  // One axis step; a single correction is enough because pos < modulus and |step| <= 3.
  function automatic logic [9:0] wrap_axis(input logic [9:0] pos, input logic [2:0] vel,
                                           input logic signed [10:0] modv);
    logic signed [10:0] p;
    logic signed [10:0] m;
    p = {1'b0, pos};
    m = {9'd0, vel[1:0]};
    p = vel[2] ? (p - m) : (p + m);
    if (p < 11'sd0) begin
      p = p + modv;
    end else if (p >= modv) begin
      p = p - modv;
    end
    return p[9:0];
  endfunction

  // Motion and lifetime update of one slot; dead slots pass through unchanged.
  function automatic logic [ENTITY_SIZE-1:0] move_entity(input logic [ENTITY_SIZE-1:0] e);
    logic [ENTITY_SIZE-1:0] r;
    r = e;
    if (e[ALIVE_B]) begin
      r[15:6]  = wrap_axis(e[15:6], e[2:0], XMOD);
      r[25:16] = wrap_axis(e[25:16], e[5:3], YMOD);
      if (e[32:26] != 7'd0) begin
        r[32:26] = e[32:26] - 7'd1;
        if (e[32:26] == 7'd1) begin
          r[ALIVE_B] = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Lowest-index dead slot.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(NUM_ENTITIES) - 1; i >= 0; i--) begin
      if (!slots_q[i][ALIVE_B]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  // Spawned entry: forced alive, off-screen coordinates clamped to 0.
  always_comb begin
    spawn_wr          = spawn_entity;
    spawn_wr[ALIVE_B] = 1'b1;
    if (spawn_entity[15:6] >= 10'(SCREEN_W)) begin
      spawn_wr[15:6] = '0;
    end
    if (spawn_entity[25:16] >= 10'(SCREEN_H)) begin
      spawn_wr[25:16] = '0;
    end
  end

  assign kill_ok     = kill_valid && (32'(kill_slot) < NUM_ENTITIES);
  assign spawn_ready = (state_q == S_IDLE) && !tick && !pending_q;

  // Next-state: sweep sequencing, tick pending, spawn write, kill override.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    slots_d      = slots_q;
    spawn_done_d = 1'b0;
    spawn_full_d = 1'b0;
    spawn_slot_d = spawn_slot_q;
    sweep_done_d = 1'b0;
    overrun_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A tick arriving together with sweep entry is absorbed by that sweep.
        if (tick || pending_q) begin
          state_d   = S_SWEEP;
          cnt_d     = '0;
          pending_d = 1'b0;
        end else if (spawn_valid) begin
          if (free_found) begin
            slots_d[free_idx] = spawn_wr;
            spawn_done_d      = 1'b1;
            spawn_slot_d      = free_idx;
          end else begin
            spawn_full_d = 1'b1;
          end
        end
      end
      S_SWEEP: begin
        // A kill on the slot under update suppresses its motion entirely.
        if (!(kill_ok && (kill_slot == cnt_q))) begin
          slots_d[cnt_q] = move_entity(slots_q[cnt_q]);
        end
        if (tick) begin
          if (pending_q) begin
            overrun_d = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end
        if (cnt_q == LAST_SLOT) begin
          state_d      = S_IDLE;
          sweep_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + SLOT_W'(1);
        end
      end
    endcase

    if (kill_ok) begin
      slots_d[kill_slot][ALIVE_B] = 1'b0;
    end
  end

  // State and table registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      spawn_done_q <= 1'b0;
      spawn_full_q <= 1'b0;
      spawn_slot_q <= '0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < int'(NUM_ENTITIES); i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      spawn_done_q <= spawn_done_d;
      spawn_full_q <= spawn_full_d;
      spawn_slot_q <= spawn_slot_d;
      sweep_done_q <= sweep_done_d;
      overrun_q    <= overrun_d;
      for (int i = 0; i < int'(NUM_ENTITIES); i++) begin
        slots_q[i] <= slots_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_ENTITIES); g++) begin : g_pack
    assign entities[g*ENTITY_SIZE +: ENTITY_SIZE] = slots_q[g];
  end

  assign busy         = (state_q == S_SWEEP);
  assign spawn_done   = spawn_done_q;
  assign spawn_full   = spawn_full_q;
  assign spawn_slot   = spawn_slot_q;
  assign sweep_done   = sweep_done_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_entity_motion_engine.sv
// tb_entity_motion_engine
//   Scoreboard bench for entity_motion_engine. A field-level reference model
//   (plain integer arrays, modulo arithmetic) predicts the table after every
//   spawn and sweep; expected events are queued at issue time and a negedge
//   monitor pops them whenever the DUT pulses spawn_done/spawn_full,
//   sweep_done or tick_overrun.

module tb_entity_motion_engine;

  localparam int N  = 7;
  localparam int ES = 34;
  localparam int SW = 320;
  localparam int SH = 240;
  localparam int TW = N * ES;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick;
  logic          spawn_valid;
  logic [ES-1:0] spawn_entity;
  logic          spawn_ready;
  logic          spawn_done;
  logic [2:0]    spawn_slot;
  logic          spawn_full;
  logic          kill_valid;
  logic [2:0]    kill_slot;
  logic [TW-1:0] entities;
  logic          busy;
  logic          sweep_done;
  logic          tick_overrun;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Reference model: one integer per field, velocity kept as its 3-bit code.
  int m_alive [N];
  int m_life  [N];
  int m_x     [N];
  int m_y     [N];
  int m_vx    [N];
  int m_vy    [N];

  typedef struct {
    bit            full;
    int            slot;
    logic [TW-1:0] tbl;
  } spawn_exp_t;

  spawn_exp_t    spawn_q [$];
  logic [TW-1:0] sweep_q [$];
  int            ovr_q   [$];

  spawn_exp_t    mon_s;
  logic [TW-1:0] mon_t;
  int            mon_o;

  entity_motion_engine dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .spawn_valid  (spawn_valid),
    .spawn_entity (spawn_entity),
    .spawn_ready  (spawn_ready),
    .spawn_done   (spawn_done),
    .spawn_slot   (spawn_slot),
    .spawn_full   (spawn_full),
    .kill_valid   (kill_valid),
    .kill_slot    (kill_slot),
    .entities     (entities),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tbl(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [ES-1:0] mk(input int alive, input int life, input int y,
                                       input int x, input int vy, input int vx);
    return {1'(alive), 7'(life), 10'(y), 10'(x), 3'(vy), 3'(vx)};
  endfunction

  function automatic int step_of(input int code);
    return ((code & 4) != 0) ? -(code & 3) : (code & 3);
  endfunction

  function automatic logic [TW-1:0] model_table();
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      t[i*ES +: ES] = mk(m_alive[i], m_life[i], m_y[i], m_x[i], m_vy[i], m_vx[i]);
    end
    return t;
  endfunction

  function automatic int model_free();
    for (int i = 0; i < N; i++) begin
      if (m_alive[i] == 0) return i;
    end
    return -1;
  endfunction

  function automatic void model_advance(input int j);
    m_x[j] = ((m_x[j] + step_of(m_vx[j])) % SW + SW) % SW;
    m_y[j] = ((m_y[j] + step_of(m_vy[j])) % SH + SH) % SH;
    if (m_life[j] != 0) begin
      m_life[j]--;
      if (m_life[j] == 0) m_alive[j] = 0;
    end
  endfunction

  // ks = killed slot (-1 none), kc = slot under update when the kill arrives.
  function automatic void model_sweep(input int ks, input int kc);
    for (int j = 0; j < N; j++) begin
      if (ks == j && j >= kc) m_alive[j] = 0;
      if (m_alive[j] != 0) model_advance(j);
      if (ks == j && j < kc) m_alive[j] = 0;
    end
  endfunction

  function automatic int model_spawn(input logic [ES-1:0] e);
    int s;
    s = model_free();
    if (s >= 0) begin
      m_alive[s] = 1;
      m_life[s]  = int'(e[32:26]);
      m_y[s]     = (int'(e[25:16]) >= SH) ? 0 : int'(e[25:16]);
      m_x[s]     = (int'(e[15:6])  >= SW) ? 0 : int'(e[15:6]);
      m_vy[s]    = int'(e[5:3]);
      m_vx[s]    = int'(e[2:0]);
    end
    return s;
  endfunction

  function automatic int fld(input int s, input int lo, input int w);
    logic [ES-1:0] e;
    e = entities[s*ES +: ES];
    return int'((e >> lo) & ((34'd1 << w) - 34'd1));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweep_done(input int t0, output int lat);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!sweep_done && g < 40);
    lat = cyc_n - t0;
    if (!sweep_done) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout: no sweep_done within %0d cycles", g);
      lat = -1;
    end
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic do_spawn(input logic [ES-1:0] e);
    int s;
    spawn_exp_t x;
    spawn_valid  = 1'b1;
    spawn_entity = e;
    s = model_spawn(e);
    x.full = (s < 0);
    x.slot = (s < 0) ? 0 : s;
    x.tbl  = model_table();
    spawn_q.push_back(x);
    @(negedge clk);
    chk("spawn_ready_idle", 64'(spawn_ready), 64'd1);
    cyc();
    spawn_valid = 1'b0;
  endtask

  task automatic do_kill(input int s);
    kill_valid = 1'b1;
    kill_slot  = 3'(s);
    if (s < N) m_alive[s] = 0;
    cyc();
    kill_valid = 1'b0;
  endtask

  task automatic do_tick_kill(input int ks, input int kc);
    int t0;
    int lat;
    t0   = cyc_n;
    tick = 1'b1;
    model_sweep(ks, kc);
    sweep_q.push_back(model_table());
    @(negedge clk);
    chk("spawn_ready_low_on_tick", 64'(spawn_ready), 64'd0);
    cyc();
    tick = 1'b0;
    chk("busy_in_sweep", 64'(busy), 64'd1);
    if (ks >= 0) begin
      repeat (kc) cyc();
      kill_valid = 1'b1;
      kill_slot  = 3'(ks);
      cyc();
      kill_valid = 1'b0;
    end
    wait_sweep_done(t0, lat);
    if (lat >= 0) chk("sweep_latency", 64'(lat), 64'(N + 1));
    cyc();
  endtask

  task automatic do_overlap();
    int t0;
    int l1;
    int l2;
    t0   = cyc_n;
    tick = 1'b1;
    model_sweep(-1, 0);
    sweep_q.push_back(model_table());
    model_sweep(-1, 0);
    sweep_q.push_back(model_table());
    ovr_q.push_back(1);
    cyc();
    cyc();
    cyc();
    tick = 1'b0;
    wait_sweep_done(t0, l1);
    wait_sweep_done(t0, l2);
    if (l1 >= 0 && l2 >= 0) chk("back_to_back_gap", 64'(l2 - l1), 64'(N + 1));
    cyc();
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset_n) begin
      if (spawn_done || spawn_full) begin
        if (spawn_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spawn_unexpected: done=%0b full=%0b with nothing outstanding", spawn_done, spawn_full);
        end else begin
          mon_s = spawn_q.pop_front();
          chk("spawn_full_flag", 64'(spawn_full), 64'(mon_s.full));
          chk("spawn_done_flag", 64'(spawn_done), 64'(!mon_s.full));
          if (!mon_s.full) chk("spawn_slot", 64'(spawn_slot), 64'(mon_s.slot));
          chk_tbl("spawn_table", entities, mon_s.tbl);
        end
      end
      if (sweep_done) begin
        if (sweep_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sweep_unexpected: sweep_done with nothing outstanding");
        end else begin
          mon_t = sweep_q.pop_front();
          chk_tbl("sweep_table", entities, mon_t);
        end
      end
      if (tick_overrun) begin
        if (ovr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL overrun_unexpected: tick_overrun with nothing outstanding");
        end else begin
          mon_o = ovr_q.pop_front();
          chk("tick_overrun", 64'(tick_overrun), 64'(mon_o));
        end
      end
    end
  end

  initial begin
    logic [ES-1:0] e;
    int op;
    int sx;
    int sy;
    reset_n      = 1'b0;
    tick         = 1'b0;
    spawn_valid  = 1'b0;
    spawn_entity = '0;
    kill_valid   = 1'b0;
    kill_slot    = '0;
    for (int i = 0; i < N; i++) begin
      m_alive[i] = 0; m_life[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_tbl("reset_entities", entities, '0);
    chk("reset_spawn_ready", 64'(spawn_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_flags", 64'({spawn_done, spawn_full, sweep_done, tick_overrun}), 64'd0);
    reset_n = 1'b1;
    cyc();

    // Ship at (20,10) moving vx=-2, vy=+1.
    do_spawn(mk(1, 0, 10, 20, 3'b001, 3'b110));
    chk("t1_spawn_done", 64'(spawn_done), 64'd1);
    chk("t1_spawn_slot", 64'(spawn_slot), 64'd0);
    repeat (11) do_tick_kill(-1, 0);
    chk("t2_x_wrap", 64'(fld(0, 6, 10)), 64'd318);
    chk("t2_y", 64'(fld(0, 16, 10)), 64'd21);

    // Corner wrap on both axes.
    do_spawn(mk(1, 0, 239, 319, 3'b001, 3'b011));
    do_tick_kill(-1, 0);
    chk("t3_x_wrap", 64'(fld(1, 6, 10)), 64'd2);
    chk("t3_y_wrap", 64'(fld(1, 16, 10)), 64'd0);

    // Shot with life 2 expires on the second tick.
    do_spawn(mk(1, 2, 50, 100, 3'b000, 3'b001));
    do_tick_kill(-1, 0);
    chk("t4_life1", 64'(fld(2, 26, 7)), 64'd1);
    chk("t4_alive1", 64'(fld(2, 33, 1)), 64'd1);
    do_tick_kill(-1, 0);
    chk("t4_dead", 64'(fld(2, 33, 1)), 64'd0);
    chk("t4_life0", 64'(fld(2, 26, 7)), 64'd0);
    chk("t4_x_moved", 64'(fld(2, 6, 10)), 64'd102);
    do_tick_kill(-1, 0);
    chk("t4_frozen_x", 64'(fld(2, 6, 10)), 64'd102);

    // Fill the table, overflow, then reuse a killed slot.
    while (model_free() >= 0) begin
      do_spawn(mk(1, 0, $urandom_range(0, 239), $urandom_range(0, 319),
                  $urandom_range(0, 7), $urandom_range(0, 7)));
    end
    do_spawn(mk(1, 0, 5, 5, 1, 1));
    chk("t5_spawn_full", 64'(spawn_full), 64'd1);
    do_kill(3);
    do_spawn(mk(0, 0, 700, 900, 2, 5));
    chk("t5_reuse_slot3", 64'(spawn_slot), 64'd3);
    chk("t5_clamp_x", 64'(fld(3, 6, 10)), 64'd0);

    // Overlapping ticks, then a kill on the slot currently being swept.
    do_overlap();
    sx = m_x[4];
    sy = m_y[4];
    do_tick_kill(4, 4);
    chk("t6_kill_dead", 64'(fld(4, 33, 1)), 64'd0);
    chk("t6_kill_x_kept", 64'(fld(4, 6, 10)), 64'(sx));
    chk("t6_kill_y_kept", 64'(fld(4, 16, 10)), 64'(sy));

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        e = mk($urandom_range(0, 1), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4),
               $urandom_range(0, 1023), $urandom_range(0, 1023),
               $urandom_range(0, 7), $urandom_range(0, 7));
        do_spawn(e);
      end else if (op <= 5) begin
        do_tick_kill(-1, 0);
      end else if (op == 6) begin
        do_kill($urandom_range(0, 7));
      end else if (op <= 8) begin
        do_tick_kill($urandom_range(0, 6), $urandom_range(0, 6));
      end else begin
        do_overlap();
      end
    end

    repeat (5) cyc();
    chk("spawn_q_drained", 64'(spawn_q.size()), 64'd0);
    chk("sweep_q_drained", 64'(sweep_q.size()), 64'd0);
    chk("ovr_q_drained", 64'(ovr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
